// File: rtl/icache_direct_mapped_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Contents: default geometry, the controller state type, the address field
// layout for the default geometry, and a line-alignment helper.
// Optional feature macro used by the top: ICACHE_PERF_EN (hit/miss counters).
package icache_direct_mapped_pkg;

  localparam int unsigned ARCH_LEN              = 32;
  localparam int unsigned ICACHE_LINES          = 4;
  localparam int unsigned ICACHE_WORDS_PER_LINE = 4;

  localparam int unsigned ICACHE_OFF_W = $clog2(ICACHE_WORDS_PER_LINE);
  localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned ICACHE_TAG_W = ARCH_LEN - ICACHE_IDX_W - ICACHE_OFF_W - 2;

  typedef enum logic {
    READY,
    MISS
  } icache_state_t;

  // Field layout of a fetch byte address for the default geometry.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] index;
    logic [ICACHE_OFF_W-1:0] offset;
    logic [1:0]              byte_off;
  } icache_addr_t;

  // Zero the word-offset and byte bits, giving the refill address of a line.
  function automatic logic [ARCH_LEN-1:0] line_align(input logic [ARCH_LEN-1:0] addr,
                                                     input int unsigned         off_w);
    logic [ARCH_LEN-1:0] mask;
    mask = '1 << (off_w + 2);
    return addr & mask;
  endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Modports:
//   slave  - the cache: takes req_valid/req_addr/invalidate/mem_valid/mem_data,
//            drives resp_valid/resp_inst/stall_out/mem_req/mem_addr.
//   master - the environment (fetch stage + main memory), opposite directions.
interface icache_direct_mapped_if
  import icache_direct_mapped_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) ();

  logic                         req_valid;
  logic [ARCH_LEN-1:0]          req_addr;
  logic                         invalidate;
  logic                         resp_valid;
  logic [31:0]                  resp_inst;
  logic                         stall_out;
  logic                         mem_req;
  logic [ARCH_LEN-1:0]          mem_addr;
  logic                         mem_valid;
  logic [32*WORDS_PER_LINE-1:0] mem_data;

  modport slave (
    input  req_valid, req_addr, invalidate, mem_valid, mem_data,
    output resp_valid, resp_inst, stall_out, mem_req, mem_addr
  );

  modport master (
    output req_valid, req_addr, invalidate, mem_valid, mem_data,
    input  resp_valid, resp_inst, stall_out, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_direct_mapped_array.sv
// Valid/tag/data storage of the direct-mapped instruction cache.
// Ports:
//   clk                   clock
//   rd_idx_i              combinational read index
//   rd_valid_o/tag/line   contents of the addressed line
//   wr_en_i ... wr_valid_i one synchronous write port (data, tag, valid bit)
//   clr_all_i             synchronous clear of every valid bit
// Only the valid bits are cleared; tag and data storage carry no reset.
module icache_array #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned TAG_W     = 26,
  parameter int unsigned LINE_W    = 128
) (
  input  logic                         clk,
  input  logic [$clog2(NUM_LINES)-1:0] rd_idx_i,
  output logic                         rd_valid_o,
  output logic [TAG_W-1:0]             rd_tag_o,
  output logic [LINE_W-1:0]            rd_line_o,
  input  logic                         wr_en_i,
  input  logic [$clog2(NUM_LINES)-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]             wr_tag_i,
  input  logic [LINE_W-1:0]            wr_line_i,
  input  logic                         wr_valid_i,
  input  logic                         clr_all_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  // A write in the same cycle as a clear-all wins for its own line.
  always_ff @(posedge clk) begin
    if (clr_all_i) begin
      valid_q <= '0;
    end
    if (wr_en_i) begin
      valid_q[wr_idx_i] <= wr_valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache between the fetch stage and main
// memory. Hits answer in the same cycle; a miss raises stall_out and refills a
// whole line. invalidate (fence.i) clears every valid bit.
// Ports:
//   clk    clock
//   rst    synchronous, active-low reset
//   bus    icache_direct_mapped_if.slave (fetch request/response + line refill)
//   hit_count, miss_count  (only with ICACHE_PERF_EN defined) wrapping counters
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
#(
  parameter int unsigned NUM_LINES      = ICACHE_LINES,
  parameter int unsigned WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst,
  icache_direct_mapped_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = ARCH_LEN - IDX_W - OFF_W - 2;
  localparam int unsigned LINE_W = 32 * WORDS_PER_LINE;

  icache_state_t       state_q;
  logic                inv_pending_q;
  logic                mem_req_q;
  logic [ARCH_LEN-1:0] mem_addr_q;

  logic [OFF_W-1:0]    req_off;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_line;

  logic                hit;
  logic                miss;
  logic                fill;
  logic                fill_invalid;
  logic                clr_all;
  logic                stall;

  assign req_off = bus.req_addr[OFF_W+1:2];
  assign req_idx = bus.req_addr[OFF_W+2 +: IDX_W];
  assign req_tag = bus.req_addr[ARCH_LEN-1 -: TAG_W];

  icache_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .LINE_W    (LINE_W)
  ) u_array (
    .clk        (clk),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (fill),
    .wr_idx_i   (mem_addr_q[OFF_W+2 +: IDX_W]),
    .wr_tag_i   (mem_addr_q[ARCH_LEN-1 -: TAG_W]),
    .wr_line_i  (bus.mem_data),
    .wr_valid_i (!fill_invalid),
    .clr_all_i  (clr_all)
  );

  // Responses are qualified with rst so nothing is reported during reset.
  always_comb begin
    hit          = 1'b0;
    miss         = 1'b0;
    fill         = 1'b0;
    fill_invalid = 1'b0;
    clr_all      = 1'b0;
    stall        = 1'b0;
    if (rst) begin
      if (state_q == READY) begin
        hit     = bus.req_valid && !bus.invalidate && rd_valid && (rd_tag == req_tag);
        miss    = bus.req_valid && !bus.invalidate && !(rd_valid && (rd_tag == req_tag));
        clr_all = bus.invalidate;
        stall   = miss || bus.invalidate;
      end else begin
        stall = 1'b1;
        fill  = bus.mem_valid;
        // An invalidate arriving on the fill cycle itself counts as pending.
        fill_invalid = inv_pending_q || bus.invalidate;
        clr_all      = bus.mem_valid && fill_invalid;
      end
    end else begin
      clr_all = 1'b1;
    end
  end

  assign bus.resp_valid = hit;
  assign bus.resp_inst  = rd_line[32*req_off +: 32];
  assign bus.stall_out  = stall;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= READY;
      inv_pending_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
    end else begin
      case (state_q)
        READY: begin
          if (miss) begin
            state_q    <= MISS;
            mem_req_q  <= 1'b1;
            mem_addr_q <= line_align(bus.req_addr, OFF_W);
          end
        end
        MISS: begin
          if (bus.invalidate) begin
            inv_pending_q <= 1'b1;
          end
          if (bus.mem_valid) begin
            state_q       <= READY;
            mem_req_q     <= 1'b0;
            inv_pending_q <= 1'b0;
          end
        end
        default: state_q <= READY;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (miss) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, read-only instruction cache between fetch_stage (requester) and main_memory (line refill source).
- Hits return the 32-bit instruction in the same cycle.
- Misses raise stall_out, which feeds the fetch stall (stall_fet_out path), while a full line is refilled from memory.
- Also supports whole-cache invalidation (fence.i).

Parameters:
- NUM_LINES, 4, number of cache lines; power of two, ≥2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two; line width = 32*WORDS_PER_LINE.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  fetch presents an address this cycle.
- req_addr  in  ARCH_LEN  fetch byte address; bits [1:0] ignored.
- invalidate  in  1  clear all valid bits (fence.i).
- resp_valid  out  1  resp_inst holds a valid hit this cycle.
- resp_inst  out  32  instruction word.
- stall_out  out  1  miss or refill in progress; fetch must hold req_addr.
- mem_req  out  1  line refill request, held until mem_valid.
- mem_addr  out  ARCH_LEN  line-aligned refill address (offset bits zero).
- mem_valid  in  1  mem_data valid; single-cycle pulse.
- mem_data  in  32*WORDS_PER_LINE  full line; word 0 in bits [31:0].

Behaviour:
- Address split:
  - offset = addr[log2(WORDS_PER_LINE)+1:2]
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits
- Reset (rst=0 at posedge):
  - state READY, all valid bits 0, inv_pending 0.
  - resp_valid, stall_out, mem_req, mem_addr all 0.
  - Data and tag arrays are not reset.
- State READY:
  - Hit = req_valid & valid[index] & tag match & !invalidate.
  - On hit: combinationally resp_valid=1, resp_inst=line[offset], stall_out=0. Zero-cycle latency.
  - On miss (req_valid & !hit & !invalidate): stall_out=1 combinationally; latch line address; next state MISS.
  - req_valid=0: resp_valid=0, stall_out=0, no state change.
- State MISS:
  - mem_req=1, mem_addr=latched line address, stall_out=1, resp_valid=0.
  - On the mem_valid cycle:
    - write line data and tag;
    - set valid[index]=!inv_pending (and clear all others if inv_pending);
    - clear inv_pending; next state READY.
  - mem_req deasserts the cycle after mem_valid.
- Timing: miss detected cycle N, mem_req rises N+1, mem_valid at cycle M ≥ N+1. stall_out is high N..M inclusive. Cycle M+1 is READY and the re-presented address hits.
- invalidate:
  - In READY: clear all valid bits at the edge. resp_valid=0 and stall_out=1 for that cycle; no memory request.
  - In MISS: set inv_pending. The in-flight fill completes but is written invalid, so fetch misses again.
- mem_valid outside MISS: ignored.
- req_addr changes during MISS: ignored; refill uses the latched address.
- Reset mid-refill: return to READY, mem_req drops next cycle; a later stray mem_valid is ignored.
- Branch redirect during a miss: the refill completes normally; fetch re-presents the new PC.

Optional Feature:
- Macro ICACHE_PERF_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Counters are reset to 0 and wrap at 2^32.
  - hit_count increments on each READY hit cycle.
  - miss_count increments once per READY->MISS transition.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package (constants_pkg/structure_pkg):
  - ICACHE_LINES and ICACHE_WORDS_PER_LINE defaults;
  - icache_state_t enum {READY, MISS};
  - icache_addr_t packed struct {tag, index, offset}.
- One sub-module, icache_array: valid/tag/data storage with combinational read, one synchronous write port, and a synchronous clear-all for valid bits.

Test Plan:
- Cold miss: reset, req 0x0000_0000 → stall_out=1 at N, mem_req=1/mem_addr=0x0 at N+1. mem_valid at N+3 with line {0x4,0x3,0x2,0x1} → at N+4 resp_valid=1, resp_inst=0x1.
- Same-line hits: after the fill, req 0x4, 0x8, 0xC → resp_inst 0x2, 0x3, 0x4 each cycle, stall_out=0, mem_req=0.
- Conflict eviction: fill 0x00, then req 0x40 (same index, different tag) → miss, refill from mem_addr=0x40; then req 0x00 → miss again.
- Invalidate in MISS: miss on 0x10, assert invalidate before mem_valid → the fill completes, and the next req 0x10 misses again (mem_req reasserted).
- Spurious/reset cases:
  - mem_valid pulse in READY → no array change.
  - rst=0 during MISS → mem_req=0 next cycle; a following mem_valid is ignored and req 0x0 misses.
- ICACHE_PERF_EN: 1 miss followed by 3 hits → miss_count=1, hit_count=3.
